inst_decode_stage: RTL
======================

# inst_decode_stage

Registered RV32I/RV64I instruction decode stage sitting between the fetch stage and the register-file read / execute stage of the core. Classifies each instruction into a format type, extracts register indices and function fields, generates the sign-extended immediate, and flags illegal opcodes. Adds load/fence opcode coverage, a `valid`/`ready` handshake with one-deep output buffering, and pipeline flush over the previous purely combinational type decoder.

## Interface
- `XLEN`, 32: datapath width for PC and immediate; legal values 32 or 64.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard the held instruction and any instruction offered this cycle.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `in_inst`  in  32  raw instruction word.
- `in_pc`  in  XLEN  PC of `in_inst`.
- `out_valid`  out  1  decoded bundle valid.
- `out_ready`  in  1  downstream consumes bundle this cycle.
- `out_pc`  out  XLEN  registered PC.
- `out_op_type`  out  3  format: I=0, S=2, B=3, U=4, J=5, R=6; 1 and 7 never driven.
- `out_opcode`  out  7  `inst[6:0]`.
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  `inst[11:7]`, `inst[19:15]`, `inst[24:20]`.
- `out_funct3`  out  3  `inst[14:12]`; `out_funct7`  out  7  `inst[31:25]`.
- `out_imm`  out  XLEN  immediate, sign-extended from `inst[31]`.
- `out_illegal`  out  1  opcode not in the decode list.

## Operation
- Opcode map: 0110011→R; 0010011, 0000011, 1100111, 1110011, 0001111→I; 0100011→S; 1100011→B; 1101111→J; 0110111, 0010111→U; any other opcode→I (0) with illegal set.
- `inst[1:0]` ≠ 2'b11 is illegal regardless of the remaining opcode bits.
- Immediate per type: I `{inst[31:20]}`; S `{inst[31:25],inst[11:7]}`; B `{inst[31],inst[7],inst[30:25],inst[11:8],1'b0}`; U `{inst[31:12],12'b0}`; J `{inst[31],inst[19:12],inst[20],inst[30:21],1'b0}`; R → 0. All sign-extended to XLEN (U sign-extends bit 31 when XLEN=64).
- Field outputs are always raw slices regardless of type; the consumer ignores unused fields.
- Buffer: one output register. `in_ready = !out_valid || out_ready`, combinational, not gated by `flush`.
- Accept: `in_valid && in_ready && !flush` loads all `out_*` registers and sets `out_valid`.
- Drain: `out_valid && out_ready` with no accept clears `out_valid`; data registers hold their value.
- Simultaneous drain + accept: the new bundle replaces the old one, `out_valid` stays 1.
- Flush: `out_valid` ← 0 next cycle; the offered input is dropped; it overrides accept and drain.
- Stall: `out_valid && !out_ready` holds every output bit-stable.

## Timing
- Latency 1 cycle from accept to `out_valid`; throughput 1 instruction/cycle when `out_ready` is held high.
- Reset (`rst` high at an edge): `out_valid`=0 and every data output = 0 on the following cycle; it overrides flush and accept.
- Reset mid-stall drops the held bundle; the first accept is possible in the cycle after `rst` deasserts.
- No combinational path from `in_*` to `out_*`; only `out_ready`/`out_valid` → `in_ready` is combinational.

## Configuration
- `INST_DECODE_ILLEGAL_CHECK_EN`:
  - Defined: illegal detection as specified above.
  - Undefined: `out_illegal` is tied to 0, unknown opcodes decode as I, and the `inst[1:0]` check is removed. Saves logic on FPGA test builds.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid`=1 → `out_valid`=0, `out_imm`=0, `out_op_type`=0.
- Per-format decode, `out_ready`=1: `addi x1,x0,-1` (0xFFF00093) → type 0, rd=1, imm=0xFFFFFFFF; `sw` 0x00112623 → type 2, imm=12; `beq` 0xFE000EE3 → type 3, imm=-4; `lui` 0x12345037 → type 4, imm=0x12345000; `jal` 0x008000EF → type 5, imm=8; `add` 0x002081B3 → type 6, imm=0. Each result arrives 1 cycle after accept.
- Backpressure: accept 3 instructions back-to-back with `out_ready`=0 from cycle 2 for 4 cycles → `in_ready`=0 while full, bundle 1 held stable, no instruction lost or duplicated; output order is 1, 2, 3.
- Flush while full and offering a new instruction → `out_valid`=0 next cycle, new instruction not delivered; the next accept after flush decodes normally.
- Illegal instructions: 0x0000007F and 0x00000013 with `inst[1:0]`=00 (0x00000010) → `out_illegal`=1 and type 0 with the macro defined; `out_illegal`=0 without it.
- XLEN=64: `lui` 0x80000037 → `out_imm`=0xFFFFFFFF80000000; `out_pc` carries 64-bit PC 0x0000_0001_0000_0004 through unchanged.

Source files
------------

// File: rtl/inst_decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_decode_stage_if
// Description : Fetch-side and execute-side handshake/data bundle for the
//               instruction decode stage. The decode stage is the slave;
//               the surrounding pipeline (or a bench) is the master.
// Revision    : 1.0  initial release
// ============================================================================
interface inst_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [2:0]      out_op_type;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_op_type, out_opcode,
               out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
               out_imm, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_op_type, out_opcode,
               out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
               out_imm, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/inst_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : inst_decode_stage
// Description : Registered RV32I/RV64I decode stage. Classifies the format,
//               slices register/function fields, builds the sign-extended
//               immediate and flags illegal opcodes. One-deep output buffer
//               with valid/ready handshake and pipeline flush.
//               Optional feature macro: INST_DECODE_ILLEGAL_CHECK_EN
//               (defined -> illegal detection; undefined -> out_illegal = 0).
// Revision    : 1.0  initial release
// ============================================================================
module inst_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    inst_decode_stage_if.slave bus
);
    localparam logic [2:0] c_type_i = 3'd0;
    localparam logic [2:0] c_type_s = 3'd2;
    localparam logic [2:0] c_type_b = 3'd3;
    localparam logic [2:0] c_type_u = 3'd4;
    localparam logic [2:0] c_type_j = 3'd5;
    localparam logic [2:0] c_type_r = 3'd6;

    localparam logic [6:0] c_op_op     = 7'b0110011;
    localparam logic [6:0] c_op_opimm  = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_system = 7'b1110011;
    localparam logic [6:0] c_op_fence  = 7'b0001111;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    logic [31:0]     w_inst;
    logic [6:0]      w_opcode;
    logic [2:0]      w_type;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic            w_accept;

    logic            r_out_valid;
    logic [XLEN-1:0] r_pc;
    logic [2:0]      r_op_type;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_imm;
    logic            r_illegal;

    assign w_inst   = bus.in_inst;
    assign w_opcode = w_inst[6:0];

    // Opcode to format type; anything unrecognised falls back to I.
    always_comb begin
        w_type = c_type_i;
        case (w_opcode)
            c_op_op:                     w_type = c_type_r;
            c_op_store:                  w_type = c_type_s;
            c_op_branch:                 w_type = c_type_b;
            c_op_jal:                    w_type = c_type_j;
            c_op_lui, c_op_auipc:        w_type = c_type_u;
            default:                     w_type = c_type_i;
        endcase
    end

`ifdef INST_DECODE_ILLEGAL_CHECK_EN
    // Legal only for listed opcodes; inst[1:0] != 11 is caught explicitly
    // so a future opcode-list edit cannot silently admit compressed encodings.
    assign w_illegal = !(w_opcode inside {c_op_op, c_op_opimm, c_op_load,
                                          c_op_jalr, c_op_system, c_op_fence,
                                          c_op_store, c_op_branch, c_op_jal,
                                          c_op_lui, c_op_auipc})
                       || (w_inst[1:0] != 2'b11);
`else
    assign w_illegal = 1'b0;
`endif

    // Immediate assembly per format at 32 bits, sign-extended to XLEN below.
    always_comb begin
        w_imm32 = 32'd0;
        case (w_type)
            c_type_i: w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
            c_type_s: w_imm32 = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            c_type_b: w_imm32 = {{19{w_inst[31]}}, w_inst[31], w_inst[7],
                                 w_inst[30:25], w_inst[11:8], 1'b0};
            c_type_u: w_imm32 = {w_inst[31:12], 12'd0};
            c_type_j: w_imm32 = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12],
                                 w_inst[20], w_inst[30:21], 1'b0};
            default:  w_imm32 = 32'd0;
        endcase
    end

    assign w_imm = XLEN'($signed(w_imm32));

    // in_ready deliberately ignores flush so the handshake stays a pure
    // function of buffer occupancy and downstream readiness.
    assign bus.in_ready = !r_out_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready && !bus.flush;

    // Output buffer: reset > flush > accept (load) > drain; stall holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_pc        <= '0;
            r_op_type   <= c_type_i;
            r_inst      <= 32'd0;
            r_imm       <= '0;
            r_illegal   <= 1'b0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_pc        <= bus.in_pc;
            r_op_type   <= w_type;
            r_inst      <= w_inst;
            r_imm       <= w_imm;
            r_illegal   <= w_illegal;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Field outputs are raw slices of the held word regardless of format.
    assign bus.out_valid   = r_out_valid;
    assign bus.out_pc      = r_pc;
    assign bus.out_op_type = r_op_type;
    assign bus.out_opcode  = r_inst[6:0];
    assign bus.out_rd      = r_inst[11:7];
    assign bus.out_rs1     = r_inst[19:15];
    assign bus.out_rs2     = r_inst[24:20];
    assign bus.out_funct3  = r_inst[14:12];
    assign bus.out_funct7  = r_inst[31:25];
    assign bus.out_imm     = r_imm;
    assign bus.out_illegal = r_illegal;
endmodule
`default_nettype wire
